// File: rtl/ddr_traffic_gen.sv
// DDR controller traffic generator: writes WORDS pattern blocks, reads them back and checks them.
// Optional first-miscompare address capture is enabled by defining DDR_TRAFFIC_ERR_CAPTURE_EN.
module ddr_traffic_gen #(
  parameter int DATA_W   = 256,
  parameter int ADDR_W   = 30,
  parameter int WORDS    = 8,
  parameter int STRIDE   = 32,
  parameter int INTERVAL = 50000000
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [1:0]        mode,
  input  logic              ram_rdy,
  input  logic [DATA_W-1:0] block_out,
  output logic              ram_en,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_to_ram,
  output logic              busy,
  output logic              fail,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic [7:0]        led
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam int                SH_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(STRIDE);
  localparam logic [63:0]       SPAN_64   = 64'(WORDS) * 64'(STRIDE);
  localparam logic [ADDR_W-1:0] SPAN_A    = ADDR_W'(SPAN_64);
  localparam logic [15:0]       LAST_IDX  = 16'(WORDS - 1);
  localparam logic [31:0]       WAIT_LAST = 32'(INTERVAL - 1);

  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic              r_cont;
  logic [15:0]       r_idx;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_blk_addr;
  logic [31:0]       r_wait_cnt;
  logic              r_en;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_fail;
  logic [15:0]       r_pass;
  logic [15:0]       r_err_cnt;
  logic [7:0]        r_led;

  logic              w_busy;
  logic              w_last;
  logic [31:0]       w_n;
  logic [SH_W-1:0]   w_sh;
  logic [DATA_W-1:0] w_pattern;
  logic [ADDR_W-1:0] w_next_base;
  logic              w_miscmp;

  function automatic logic [DATA_W-1:0] block_pattern(input logic [1:0]        m,
                                                      input logic [SH_W-1:0]   sh,
                                                      input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ext;
    ext = DATA_W'(a);
    case (m)
      2'd1:    block_pattern = ext;
      2'd2:    block_pattern = ~ext;
      default: block_pattern = DATA_W'(1) << sh;
    endcase
  endfunction

  // Block sequence number n = pass_cnt*WORDS + i fits in 32 bits for the allowed WORDS range.
  assign w_n         = 32'(r_pass) * 32'(WORDS) + 32'(r_idx);
  assign w_sh        = SH_W'(w_n % 32'(DATA_W));
  assign w_pattern   = block_pattern(r_mode, w_sh, r_blk_addr);
  assign w_last      = (r_idx == LAST_IDX);
  assign w_next_base = r_base + SPAN_A;
  assign w_busy      = (r_state != S_IDLE);
  assign w_miscmp    = (r_state == S_RD) && r_en && ram_rdy && (block_out != r_data);

  // During reads data_to_ram keeps the expected block, which is what block_out is compared against.
  always_ff @(posedge ui_clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'd0;
      r_cont     <= 1'b0;
      r_idx      <= '0;
      r_base     <= '0;
      r_blk_addr <= '0;
      r_wait_cnt <= '0;
      r_en       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_pass     <= '0;
      r_led      <= '0;
    end else begin
      r_led <= {r_fail, w_busy, r_pass[5:0]};
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode     <= mode;
            r_cont     <= continuous;
            r_idx      <= '0;
            r_base     <= '0;
            r_blk_addr <= '0;
            r_state    <= S_WR;
          end
        end
        S_WR, S_RD: begin
          if (!r_en) begin
            r_en   <= 1'b1;
            r_wr   <= (r_state == S_WR);
            r_addr <= r_blk_addr;
            r_data <= w_pattern;
          end else if (ram_rdy) begin
            r_en <= 1'b0;
            if (!w_last) begin
              r_idx      <= r_idx + 16'd1;
              r_blk_addr <= r_blk_addr + STRIDE_A;
            end else begin
              r_idx <= '0;
              if (r_state == S_WR) begin
                r_state    <= S_RD;
                r_blk_addr <= r_base;
              end else begin
                r_pass <= r_pass + 16'd1;
                if (r_cont) begin
                  r_state    <= S_WAIT;
                  r_base     <= w_next_base;
                  r_blk_addr <= w_next_base;
                  r_wait_cnt <= '0;
                end else begin
                  r_state <= S_IDLE;
                end
              end
            end
          end
        end
        S_WAIT: begin
          // The first write is issued straight from WAIT so exactly INTERVAL cycles pass with ram_en low.
          if (r_wait_cnt == WAIT_LAST) begin
            r_state <= S_WR;
            r_en    <= 1'b1;
            r_wr    <= 1'b1;
            r_addr  <= r_blk_addr;
            r_data  <= w_pattern;
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ui_clk or negedge rst) begin
    if (!rst) begin
      r_fail    <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_miscmp) begin
      r_fail <= 1'b1;
      if (r_err_cnt != 16'hFFFF) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

`ifdef DDR_TRAFFIC_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] r_err_addr;

  always_ff @(posedge ui_clk or negedge rst) begin
    if (!rst) begin
      r_err_addr <= '0;
    end else if (w_miscmp && !r_fail) begin
      r_err_addr <= r_addr;
    end
  end

  assign err_addr = r_err_addr;
`else
  assign err_addr = '0;
`endif

  assign ram_en      = r_en;
  assign ram_write   = r_wr;
  assign ram_addr    = r_addr;
  assign data_to_ram = r_data;
  assign busy        = w_busy;
  assign fail        = r_fail;
  assign pass_cnt    = r_pass;
  assign err_cnt     = r_err_cnt;
  assign led         = r_led;

endmodule
